// File: rtl/cg_iteration_sequencer.sv
// Control sequencer for the conjugate-gradient datapath: steps through the CG stages,
// issues stage go pulses and read beats, holds rsold/rsnew and reports solve status.
module cg_iteration_sequencer #(
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned NO_OF_UNITS   = 8,
    parameter int unsigned LEN_WIDTH     = 32,
    parameter int unsigned ITER_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [LEN_WIDTH-1:0]     total,
    input  logic [ITER_WIDTH-1:0]    max_iter,
    input  logic [ELEMENT_WIDTH-1:0] tolerance,
    input  logic [ELEMENT_WIDTH-1:0] dot_result,
    input  logic                     rd_ready,
    input  logic [6:0]               stage_done,
    output logic [6:0]               stage_go,
    output logic                     rd_strobe,
    output logic [ELEMENT_WIDTH-1:0] rs_old,
    output logic [ELEMENT_WIDTH-1:0] rs_new,
    output logic [ITER_WIDTH-1:0]    iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     timeout,
    output logic                     err_len
);

    typedef enum logic [3:0] {
        StIdle, StRsold, StMatvec, StAlpha, StUpdXr, StRsnew, StCheck, StBeta, StUpdP, StDone
    } state_e;

    localparam logic [LEN_WIDTH-1:0] Units = LEN_WIDTH'(NO_OF_UNITS);

    state_e                   state_q, state_d;
    logic                     first_q;
    logic                     pend_q;
    logic [LEN_WIDTH-1:0]     beats_total_q, beats_left_q, beats_calc, beats_after;
    logic [ELEMENT_WIDTH-1:0] rs_old_q, rs_new_q;
    logic [ITER_WIDTH-1:0]    iter_q;
    logic                     conv_q, tmo_q, err_q;
    logic [6:0]               cur_stage;
    logic                     hit, streaming, strobe, stream_exit, accept, cap_hit;

    always_comb begin
        beats_calc = total / Units;
        if ((total % Units) != '0) beats_calc = beats_calc + LEN_WIDTH'(1);
    end

    always_comb begin
        cur_stage = '0;
        unique case (state_q)
            StRsold:  cur_stage = 7'b0000001;
            StMatvec: cur_stage = 7'b0000010;
            StAlpha:  cur_stage = 7'b0000100;
            StUpdXr:  cur_stage = 7'b0001000;
            StRsnew:  cur_stage = 7'b0010000;
            StBeta:   cur_stage = 7'b0100000;
            StUpdP:   cur_stage = 7'b1000000;
            default:  cur_stage = '0;
        endcase
    end

    // A done pulse seen before the last beat is remembered in pend_q until the beats run out.
    assign hit         = |(stage_done & cur_stage);
    assign streaming   = (state_q == StRsold) || (state_q == StRsnew);
    assign strobe      = streaming && rd_ready && (beats_left_q != '0) && !abort;
    assign beats_after = beats_left_q - LEN_WIDTH'(strobe);
    assign stream_exit = (hit || pend_q) && (beats_after == '0);
    assign accept      = (state_q == StIdle) && start && (total != '0);
    assign cap_hit     = (max_iter != '0) && (iter_q >= max_iter);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StRsold;
            StRsold:  if (stream_exit) state_d = StMatvec;
            StMatvec: if (hit) state_d = StAlpha;
            StAlpha:  if (hit) state_d = StUpdXr;
            StUpdXr:  if (hit) state_d = StRsnew;
            StRsnew:  if (stream_exit) state_d = StCheck;
            StCheck:  state_d = (rs_new_q <= tolerance) ? StDone : StBeta;
            StBeta:   if (hit) state_d = StUpdP;
            StUpdP:   if (hit) state_d = cap_hit ? StDone : StMatvec;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort && state_q != StIdle) state_d = StIdle;
    end

    always_comb begin
        stage_go   = (first_q && !abort) ? cur_stage : '0;
        rd_strobe  = strobe;
        busy       = (state_q != StIdle) && (state_q != StDone);
        done       = (state_q == StDone);
        rs_old     = rs_old_q;
        rs_new     = rs_new_q;
        iter_count = iter_q;
        converged  = conv_q;
        timeout    = tmo_q;
        err_len    = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q        <= 1'b0;
            beats_total_q <= '0;
            beats_left_q  <= '0;
            rs_old_q      <= '0;
            rs_new_q      <= '0;
            iter_q        <= '0;
            conv_q        <= 1'b0;
            tmo_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            if (state_d != state_q) pend_q <= 1'b0;
            else if (hit)           pend_q <= 1'b1;

            if (accept) begin
                beats_total_q <= beats_calc;
                beats_left_q  <= beats_calc;
                iter_q        <= '0;
                conv_q        <= 1'b0;
                tmo_q         <= 1'b0;
                err_q         <= 1'b0;
            end else if (state_q == StIdle && start) begin
                err_q <= 1'b1;
            end else if (state_q == StUpdXr && state_d == StRsnew) begin
                beats_left_q <= beats_total_q;
            end else if (strobe) begin
                beats_left_q <= beats_after;
            end

            if (!abort) begin
                if (state_q == StRsold && stage_done[0]) rs_old_q <= dot_result;
                if (state_q == StRsnew && stage_done[4]) rs_new_q <= dot_result;
                if (state_q == StUpdXr && stage_done[3] && iter_q != '1) iter_q <= iter_q + 1'b1;
                if (state_q == StCheck && rs_new_q <= tolerance) conv_q <= 1'b1;
                if (state_q == StUpdP && stage_done[6]) begin
                    rs_old_q <= rs_new_q;
                    if (cap_hit) tmo_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed bench for cg_iteration_sequencer: cycle vector tables for streaming/abort/reset,
// plus full solves driven by a simple stage-done responder.
module tb_cg_iteration_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, rd_ready;
    logic [31:0] total, tolerance, dot_result;
    logic [15:0] max_iter;
    logic [6:0]  stage_done;
    logic [6:0]  stage_go;
    logic        rd_strobe, busy, done, converged, timeout, err_len;
    logic [31:0] rs_old, rs_new;
    logic [15:0] iter_count;

    cg_iteration_sequencer #(
        .ELEMENT_WIDTH(32), .NO_OF_UNITS(8), .LEN_WIDTH(32), .ITER_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .total(total),
        .max_iter(max_iter), .tolerance(tolerance), .dot_result(dot_result),
        .rd_ready(rd_ready), .stage_done(stage_done), .stage_go(stage_go),
        .rd_strobe(rd_strobe), .rs_old(rs_old), .rs_new(rs_new), .iter_count(iter_count),
        .busy(busy), .done(done), .converged(converged), .timeout(timeout), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int go_cnt[7];
    int strobes, done_cnt, stray;
    logic fin;

    typedef struct {
        logic       rst, st, ab, rdy;
        logic [6:0] sdone;
        logic [31:0] tot;
        logic [6:0] go;
        logic       strobe, bsy, dn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic a, input logic y,
                                input logic [6:0] sd, input logic [31:0] t,
                                input logic [6:0] g, input logic st, input logic b,
                                input logic d);
        vec_t v;
        v.rst = r; v.st = s; v.ab = a; v.rdy = y; v.sdone = sd; v.tot = t;
        v.go = g; v.strobe = st; v.bsy = b; v.dn = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        @(posedge clk); #1;
        reset = 0; start = 0; abort = 0; rd_ready = 0; stage_done = '0;
    endtask

    // Starts a solve (total=16) and answers each stage_go with its done two cycles later.
    task automatic auto_run(input logic [31:0] rsold_v, input logic [31:0] rsnew_v,
                            input int abort_mv);
        logic [6:0] want;
        int cnt;
        logic abort_pend;
        want = '0; cnt = 0; abort_pend = 0; fin = 0;
        strobes = 0; done_cnt = 0;
        for (int i = 0; i < 7; i++) go_cnt[i] = 0;
        @(posedge clk); #1;
        start = 1; total = 16; rd_ready = 1; stage_done = '0; abort = 0;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (stage_go != '0) begin
                for (int i = 0; i < 7; i++) if (stage_go[i]) go_cnt[i]++;
                want = stage_go; cnt = 2;
                if (stage_go[1] && go_cnt[1] == abort_mv) abort_pend = 1;
            end
            strobes += int'(rd_strobe);
            if (done) begin done_cnt++; fin = 1; end
            @(posedge clk); #1;
            stage_done = '0; abort = 0;
            if (abort_pend) begin
                abort = 1; abort_pend = 0; fin = 1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    stage_done = want;
                    dot_result = want[0] ? rsold_v : rsnew_v;
                end
            end
        end
        check("run_finished_in_budget", 64'(fin), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; abort = 0; rd_ready = 0; stage_done = '0; total = '0;
        max_iter = '0; tolerance = 32'h283424DC; dot_result = 32'h3F800000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {stage_go, rd_strobe, busy, done, converged, timeout, err_len},
              64'd0);
        check("reset_values", {rs_old, rs_new}, 64'd0);
        check("reset_iter", 64'(iter_count), 64'd0);

        // total=20: three beats, early done held, foreign done ignored, abort kills ALPHA go
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 0,  7'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 7'h00, 20, 7'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7'h01, 20, 7'h01, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 7'h00, 0,  7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7'h00, 0,  7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7'h04, 0,  7'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 7'h02, 0,  7'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 7'h00, 0,  7'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 7'h00, 0,  7'h00, 0, 0, 0));
        // total=16 with rd_ready toggling, then reset mid-MATVEC
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 0,  7'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 7'h00, 16, 7'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 7'h01, 16, 7'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7'h00, 16, 7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 7'h00, 16, 7'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7'h00, 16, 7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7'h00, 16, 7'h02, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 16, 7'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 7'h00, 16, 7'h00, 0, 0, 0));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            reset = tbl[i].rst; start = tbl[i].st; abort = tbl[i].ab;
            rd_ready = tbl[i].rdy; stage_done = tbl[i].sdone; total = tbl[i].tot;
            @(negedge clk);
            check($sformatf("vec%0d go/strobe/busy/done", i),
                  {stage_go, rd_strobe, busy, done},
                  {tbl[i].go, tbl[i].strobe, tbl[i].bsy, tbl[i].dn});
            if (i == 8) begin
                check("abort_keeps_rs_old", 64'(rs_old), 64'h3F800000);
                check("start_while_busy_no_err", 64'(err_len), 64'd0);
            end
        end
        idle_inputs();

        // zero-length start is rejected
        @(posedge clk); #1; start = 1; total = 0;
        @(posedge clk); #1; start = 0;
        @(negedge clk);
        check("err_len_set", {err_len, busy}, 64'b10);

        // converges on the first rsnew
        max_iter = 0; tolerance = 32'h283424DC;
        auto_run(32'h3F800000, 32'h20000000, 0);
        check("conv_done_pulses", 64'(done_cnt), 64'd1);
        check("conv_flags", {converged, timeout, err_len}, 64'b100);
        check("conv_iter", 64'(iter_count), 64'd1);
        check("conv_beta_never", 64'(go_cnt[5] + go_cnt[6]), 64'd0);
        check("conv_strobes", 64'(strobes), 64'd4);
        check("conv_rs", {rs_old, rs_new}, {32'h3F800000, 32'h20000000});
        @(negedge clk);
        check("conv_after_done", {busy, done}, 64'd0);

        // never converges, capped at 3 iterations
        max_iter = 3;
        auto_run(32'h40000000, 32'h3F800000, 0);
        check("tmo_done_pulses", 64'(done_cnt), 64'd1);
        check("tmo_flags", {converged, timeout}, 64'b01);
        check("tmo_iter", 64'(iter_count), 64'd3);
        check("tmo_go_counts", {8'(go_cnt[0]), 8'(go_cnt[1]), 8'(go_cnt[5]), 8'(go_cnt[6])},
              {8'd1, 8'd3, 8'd3, 8'd3});
        check("tmo_strobes", 64'(strobes), 64'd8);
        check("tmo_rs_old_tracks", 64'(rs_old), 64'h3F800000);

        // abort in the second MATVEC
        max_iter = 0;
        auto_run(32'h40000000, 32'h3F800000, 2);
        @(negedge clk);
        check("abort_cycle_quiet", {stage_go, rd_strobe, done}, 64'd0);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        @(posedge clk); #1; abort = 0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || done || stage_go != '0) stray++;
            @(posedge clk); #1;
        end
        check("abort_idle_after", 64'(stray), 64'd0);
        check("abort_keeps_state", {iter_count, converged, timeout, rs_old},
              {16'd1, 1'b0, 1'b0, 32'h3F800000});

        // a fresh start after abort runs clean
        auto_run(32'h3F800000, 32'h20000000, 0);
        check("rerun_done", 64'(done_cnt), 64'd1);
        check("rerun_flags", {converged, timeout, iter_count}, {1'b1, 1'b0, 16'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
